shift_out: RTL

- Serializer for the tester's output side. It takes a parallel word from the control logic and shifts it MSB-first into an external serial-in/parallel-out shifter chain (74HC595-style).
- It then pulses the chain's storage (latch) clock so all outputs update at once.
- It runs on the shared 16 MHz clk and is paced by the global 1 MHz action_pulse/action_clk pair.
- It is the write-side counterpart of the tester's serial read-in stage, and uses the same go/ready handshake.

---
 rtl/shift_out_pkg.sv | 20 ++
 rtl/shift_out.sv | 89 ++++++++
 2 files changed

// File: rtl/shift_out_pkg.sv
// Shared tester timing package: action-period constants and helpers
// used by the serial stages that are paced by action_pulse/action_clk.
package shift_out_pkg;

    localparam int ACTION_DIV            = 16;
    localparam int ACTION_PULSE_PHASE    = ACTION_DIV / 2 - 1;
    localparam int ACTION_CLK_HIGH_PHASE = ACTION_DIV / 2;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SHIFT,
        PH_STORE
    } phase_t;

    // Counter must hold 0 (idle), 1..width (shift) and width+1 (store).
    function automatic int counter_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/shift_out.sv
// MSB-first serializer into a 74HC595-style chain, paced by the action
// pulse/clock pair; pulses the storage clock once the whole word is in.
module shift_out
    import shift_out_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             action_pulse,
    input  logic             action_clk,
    input  logic [WIDTH-1:0] data,
    input  logic             go,
    output logic             ready,
    output logic             done,
    output logic             serial_data_out,
    output logic             shift_clk,
    output logic             store_clk,
    output logic             out_enable_n
);

    localparam int CW = counter_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST_SHIFT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_STORE      = CW'(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    phase_t           phase;

    always_comb begin
        phase = PH_IDLE;
        if (cnt == CNT_STORE) begin
            phase = PH_STORE;
        end else if (cnt != '0) begin
            phase = PH_SHIFT;
        end
    end

    assign ready = (cnt == '0);

    // The chain clocks copy action_clk one clk late, so serial_data_out
    // (updated on action_pulse) is always settled before their rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            shreg           <= '0;
            serial_data_out <= 1'b0;
            shift_clk       <= 1'b0;
            store_clk       <= 1'b0;
            done            <= 1'b0;
            out_enable_n    <= 1'b1;
        end else begin
            done      <= 1'b0;
            shift_clk <= (phase == PH_SHIFT) ? action_clk : 1'b0;
            store_clk <= (phase == PH_STORE) ? action_clk : 1'b0;
            if (action_pulse) begin
                case (phase)
                    PH_IDLE: begin
                        if (go) begin
                            shreg           <= data;
                            serial_data_out <= data[WIDTH-1];
                            cnt             <= CW'(1);
                        end
                    end
                    PH_SHIFT: begin
                        if (cnt == CNT_LAST_SHIFT) begin
                            serial_data_out <= 1'b0;
                            cnt             <= CNT_STORE;
                        end else begin
                            shreg           <= shreg << 1;
                            serial_data_out <= shreg[WIDTH-2];
                            cnt             <= cnt + CW'(1);
                        end
                    end
                    PH_STORE: begin
                        // Outputs are only enabled once a full word has been latched.
                        cnt          <= '0;
                        done         <= 1'b1;
                        out_enable_n <= 1'b0;
                    end
                    default: begin
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
